// File: rtl/mpm_pkg.sv
// Shared types and constants for the XOR multi-ported memory request front end.
package mpm_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned RSP_DEPTH = 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [WIDTH-1:0] data;
    } req_t;

endpackage

// File: rtl/mpm_sync_fifo.sv
// Synchronous FIFO with combinational head output; used for request queues and response buffers.
module mpm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mpm_port_frontend.sv
// Per-port queued request/response front end for the XOR multi-ported memory,
// with same-address hazard arbitration and credit-based read response buffering.
module mpm_port_frontend
    import mpm_pkg::*;
#(
    parameter int unsigned WIDTH  = mpm_pkg::WIDTH,
    parameter int unsigned DEPTH  = mpm_pkg::DEPTH,
    parameter int unsigned PORTS  = 2,
    parameter int unsigned QDEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid [PORTS-1:0],
    output logic             req_ready [PORTS-1:0],
    input  logic             req_we    [PORTS-1:0],
    input  logic [AW-1:0]    req_addr  [PORTS-1:0],
    input  logic [WIDTH-1:0] req_data  [PORTS-1:0],
    output logic             rsp_valid [PORTS-1:0],
    input  logic             rsp_ready [PORTS-1:0],
    output logic [WIDTH-1:0] rsp_data  [PORTS-1:0],
    output logic [AW-1:0]    mem_addr  [PORTS-1:0],
    output logic [WIDTH-1:0] mem_d     [PORTS-1:0],
    output logic             mem_en    [PORTS-1:0],
    input  logic [WIDTH-1:0] mem_q     [PORTS-1:0]
);

    localparam int unsigned QCW = $clog2(QDEPTH) + 1;
    localparam int unsigned RCW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned CW  = RCW + 1;

    req_t             req_head  [PORTS-1:0];
    logic             req_full  [PORTS-1:0];
    logic             req_empty [PORTS-1:0];
    logic [QCW-1:0]   req_count [PORTS-1:0];
    logic [WIDTH-1:0] rsp_head  [PORTS-1:0];
    logic             rsp_full  [PORTS-1:0];
    logic             rsp_empty [PORTS-1:0];
    logic [RCW-1:0]   rsp_count [PORTS-1:0];

    logic [PORTS-1:0] grant;
    logic [PORTS-1:0] wr_grant;
    logic [PORTS-1:0] head_we;
    logic [PORTS-1:0] inflight;
    logic             hazard;
    logic             credit_ok;

    // Lower-indexed ports win same-address write hazards; reads also need a response credit.
    always_comb begin
        grant     = '0;
        wr_grant  = '0;
        hazard    = 1'b0;
        credit_ok = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            hazard = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (wr_grant[q] && (req_head[q].addr == req_head[p].addr)) begin
                    hazard = 1'b1;
                end
            end
            credit_ok = (CW'(rsp_count[p]) + CW'(inflight[p])) < CW'(RSP_DEPTH);
            if (!req_empty[p] && !hazard) begin
                if (req_head[p].we) begin
                    grant[p]    = 1'b1;
                    wr_grant[p] = 1'b1;
                end else if (credit_ok) begin
                    grant[p] = 1'b1;
                end
            end
        end
    end

    // A granted read's data returns from the memory one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            inflight <= grant & ~head_we;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        req_t req_din;

        assign req_din    = '{we: req_we[p], addr: req_addr[p], data: req_data[p]};
        assign head_we[p] = req_head[p].we;

        assign req_ready[p] = !req_full[p];
        assign mem_en[p]    = grant[p] && req_head[p].we;
        assign mem_addr[p]  = grant[p] ? req_head[p].addr : '0;
        assign mem_d[p]     = grant[p] ? req_head[p].data : '0;
        assign rsp_valid[p] = !rsp_empty[p];
        assign rsp_data[p]  = rsp_empty[p] ? '0 : rsp_head[p];

        mpm_sync_fifo #(
            .WIDTH ($bits(req_t)),
            .DEPTH (QDEPTH)
        ) u_req_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (req_valid[p] && !req_full[p]),
            .din   (req_din),
            .pop   (grant[p]),
            .dout  (req_head[p]),
            .full  (req_full[p]),
            .empty (req_empty[p]),
            .count (req_count[p])
        );

        mpm_sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (inflight[p]),
            .din   (mem_q[p]),
            .pop   (!rsp_empty[p] && rsp_ready[p]),
            .dout  (rsp_head[p]),
            .full  (rsp_full[p]),
            .empty (rsp_empty[p]),
            .count (rsp_count[p])
        );

        a_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
            !(inflight[p] && rsp_full[p]))
            else $error("response capture into full buffer on port %0d", p);

        a_req_count_bound: assert property (@(posedge clk) disable iff (rst)
            req_count[p] <= QCW'(QDEPTH))
            else $error("request count out of range on port %0d", p);
    end

endmodule

// File: tb/tb_mpm_port_frontend.sv
// Directed scoreboard bench for mpm_port_frontend with a behavioural one-cycle-latency memory.
module tb_mpm_port_frontend;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned PORTS  = 2;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned AW     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid [PORTS-1:0];
    logic             req_ready [PORTS-1:0];
    logic             req_we    [PORTS-1:0];
    logic [AW-1:0]    req_addr  [PORTS-1:0];
    logic [WIDTH-1:0] req_data  [PORTS-1:0];
    logic             rsp_valid [PORTS-1:0];
    logic             rsp_ready [PORTS-1:0];
    logic [WIDTH-1:0] rsp_data  [PORTS-1:0];
    logic [AW-1:0]    mem_addr  [PORTS-1:0];
    logic [WIDTH-1:0] mem_d     [PORTS-1:0];
    logic             mem_en    [PORTS-1:0];
    logic [WIDTH-1:0] mem_q     [PORTS-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_q0 [$];
    logic [WIDTH-1:0] exp_q1 [$];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mpm_port_frontend #(
        .WIDTH (WIDTH), .DEPTH (DEPTH), .PORTS (PORTS), .QDEPTH (QDEPTH)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_data (req_data),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
        .mem_addr (mem_addr), .mem_d (mem_d), .mem_en (mem_en), .mem_q (mem_q)
    );

    // Memory model: read-before-write, q valid the cycle after addr.
    always @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) mem_q[p] <= mem[mem_addr[p]];
        for (int p = 0; p < PORTS; p++) if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted response is compared against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                if (exp_q0.size() == 0) check("rsp0_valid", 32'(rsp_valid[0]), 32'(exp_q0.size() != 0));
                else check("rsp0_data", 32'(rsp_data[0]), 32'(exp_q0.pop_front()));
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                if (exp_q1.size() == 0) check("rsp1_valid", 32'(rsp_valid[1]), 32'(exp_q1.size() != 0));
                else check("rsp1_data", 32'(rsp_data[1]), 32'(exp_q1.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[p] = v;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_data[p]  = d;
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp_valid[0] || rsp_valid[1]) && n < 40) begin
            step();
            n++;
        end
        check({tag, "_drain_done"}, 32'(n < 40), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int p = 0; p < PORTS; p++) begin
            check({tag, "_req_ready"}, 32'(req_ready[p]), 32'd1);
            check({tag, "_rsp_valid"}, 32'(rsp_valid[p]), 32'd0);
            check({tag, "_rsp_data"},  32'(rsp_data[p]),  32'd0);
            check({tag, "_mem_en"},    32'(mem_en[p]),    32'd0);
            check({tag, "_mem_addr"},  32'(mem_addr[p]),  32'd0);
            check({tag, "_mem_d"},     32'(mem_d[p]),     32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int cyc;
        logic rdy;

        rst = 1'b1;
        idle();
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single write on port 0, then read on port 1 with two-cycle latency.
        set_req(0, 1'b1, 1'b1, 8'd5, 8'd42);
        step();
        idle();
        check("t1_wr_en",   32'(mem_en[0]),   32'd1);
        check("t1_wr_addr", 32'(mem_addr[0]), 32'd5);
        check("t1_wr_data", 32'(mem_d[0]),    32'd42);
        step();
        check("t1_wr_popped", 32'(mem_en[0]), 32'd0);
        set_req(1, 1'b1, 1'b0, 8'd5, 8'd0);
        exp_q1.push_back(8'd42);
        step();
        idle();
        check("t1_rd_addr",  32'(mem_addr[1]),  32'd5);
        check("t1_rsp_e0",   32'(rsp_valid[1]), 32'd0);
        step();
        check("t1_rsp_e1",   32'(rsp_valid[1]), 32'd0);
        step();
        check("t1_rsp_e2",   32'(rsp_valid[1]), 32'd1);
        check("t1_rsp_data", 32'(rsp_data[1]),  32'd42);
        drain("t1");

        // Same-cycle writes to one address: port 1 held, its data wins.
        set_req(0, 1'b1, 1'b1, 8'd7, 8'h11);
        set_req(1, 1'b1, 1'b1, 8'd7, 8'h22);
        step();
        idle();
        check("t2_p0_en",   32'(mem_en[0]),   32'd1);
        check("t2_p0_d",    32'(mem_d[0]),    32'h11);
        check("t2_p1_held", 32'(mem_en[1]),   32'd0);
        step();
        check("t2_p1_en",   32'(mem_en[1]),   32'd1);
        check("t2_p1_d",    32'(mem_d[1]),    32'h22);
        check("t2_p1_addr", 32'(mem_addr[1]), 32'd7);
        check("t2_p0_idle", 32'(mem_en[0]),   32'd0);
        step();
        set_req(0, 1'b1, 1'b0, 8'd7, 8'd0);
        exp_q0.push_back(8'h22);
        step();
        idle();
        drain("t2");

        // Write on port 0 blocks a same-address read on port 1 for one cycle.
        set_req(0, 1'b1, 1'b1, 8'd3, 8'h5A);
        set_req(1, 1'b1, 1'b0, 8'd3, 8'd0);
        exp_q1.push_back(8'h5A);
        step();
        idle();
        check("t3_wr_en",     32'(mem_en[0]),   32'd1);
        check("t3_rd_held",   32'(mem_addr[1]), 32'd0);
        step();
        check("t3_rd_issued", 32'(mem_addr[1]), 32'd3);
        drain("t3");

        // Back-pressure: prefill 20..25, then six reads with responses stalled.
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 1'b1, 8'(20 + i), 8'(8'hA0 + i));
            step();
        end
        idle();
        step();
        rsp_ready[0] = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 6 && cyc < 30) begin
            set_req(0, 1'b1, 1'b0, 8'(20 + acc), 8'd0);
            rdy = req_ready[0];
            step();
            cyc++;
            if (rdy) begin
                exp_q0.push_back(8'(8'hA0 + acc));
                acc++;
            end
        end
        idle();
        check("t4_accepted",  32'(acc),          32'd6);
        check("t4_full",      32'(req_ready[0]), 32'd0);
        repeat (3) step();
        check("t4_still_full", 32'(req_ready[0]), 32'd0);
        check("t4_rsp_valid",  32'(rsp_valid[0]), 32'd1);
        check("t4_no_credit",  32'(mem_addr[0]),  32'd0);
        rsp_ready[0] = 1'b1;
        drain("t4");

        // Reset with reads in flight and queued; nothing stale may surface.
        rsp_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 1'b0, 8'(20 + i), 8'd0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        check_reset_outputs("t5_reset");
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        repeat (6) begin
            step();
            check("t5_no_stale", 32'(rsp_valid[0]), 32'd0);
        end

        // Top address stays distinct from address 0.
        set_req(0, 1'b1, 1'b1, 8'd0, 8'h3C);
        step();
        set_req(0, 1'b1, 1'b1, 8'd255, 8'hC3);
        step();
        idle();
        step();
        set_req(0, 1'b1, 1'b0, 8'd255, 8'd0);
        exp_q0.push_back(8'hC3);
        step();
        set_req(0, 1'b1, 1'b0, 8'd0, 8'd0);
        exp_q0.push_back(8'h3C);
        step();
        idle();
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
